// File: rtl/ddr_wr_burst_ctrl_if.sv
// -----------------------------------------------------------------------------
// ddr_wr_burst_ctrl_if
// Purpose : bundles the upstream word stream, the burst request channel to the
//           AXI write master and the status outputs of ddr_wr_burst_ctrl.
// Signals :
//   S_VALID / S_READY / S_DATA   upstream 256-bit word stream (VALID & READY)
//   S_FLUSH                      pulse, drain remaining words as a short burst
//   FRAME_START                  pulse, restart the write address at BASE_ADDR
//   WR_START / WR_ADRS / WR_LEN  burst request towards the write master
//   WR_READY                     write master idle
//   WR_FIFO_RE / WR_FIFO_DATA    beat pop strobe and current FIFO head word
//   WR_DONE                      one-cycle burst completion pulse
//   FIFO_LEVEL / UNDERFLOW / LEN_ERR   status
// Modports:
//   slave  : the burst controller itself
//   master : the environment (upstream source + write master)
// -----------------------------------------------------------------------------
interface ddr_wr_burst_ctrl_if #(
   parameter int unsigned FIFO_AW = 9
);
   logic                S_VALID;
   logic                S_READY;
   logic [255:0]        S_DATA;
   logic                S_FLUSH;
   logic                FRAME_START;
   logic                WR_START;
   logic [31:0]         WR_ADRS;
   logic [9:0]          WR_LEN;
   logic                WR_READY;
   logic                WR_FIFO_RE;
   logic [255:0]        WR_FIFO_DATA;
   logic                WR_DONE;
   logic [FIFO_AW:0]    FIFO_LEVEL;
   logic                UNDERFLOW;
   logic                LEN_ERR;

   modport slave (
      input  S_VALID, S_DATA, S_FLUSH, FRAME_START,
      input  WR_READY, WR_FIFO_RE, WR_DONE,
      output S_READY, WR_START, WR_ADRS, WR_LEN, WR_FIFO_DATA,
      output FIFO_LEVEL, UNDERFLOW, LEN_ERR
   );

   modport master (
      output S_VALID, S_DATA, S_FLUSH, FRAME_START,
      output WR_READY, WR_FIFO_RE, WR_DONE,
      input  S_READY, WR_START, WR_ADRS, WR_LEN, WR_FIFO_DATA,
      input  FIFO_LEVEL, UNDERFLOW, LEN_ERR
   );
endinterface

// File: rtl/ddr_wr_burst_ctrl.sv
// -----------------------------------------------------------------------------
// ddr_wr_burst_ctrl
// Purpose : buffers an upstream 256-bit word stream in a first-word-fall-through
//           FIFO and carves it into write bursts for an AXI write master. Bursts
//           walk linearly through a frame buffer [BASE_ADDR, BASE_ADDR +
//           FRAME_BYTES) and wrap back to BASE_ADDR. A flush drains a partial
//           burst; FRAME_START rewinds the address to the frame base.
// Ports   :
//   ACLK        clock, rising edge
//   ARESET      synchronous active-high reset
//   bus.*       ddr_wr_burst_ctrl_if slave view (stream in, burst request out,
//               FIFO beat interface, status flags)
// Parameters:
//   BURST_LEN   beats per full burst (1..256)
//   FIFO_AW     FIFO address width, depth = 2**FIFO_AW words
//   BASE_ADDR   frame buffer start byte address
//   FRAME_BYTES frame buffer size in bytes (multiple of 32)
// -----------------------------------------------------------------------------
module ddr_wr_burst_ctrl #(
   parameter int unsigned BURST_LEN   = 64,
   parameter int unsigned FIFO_AW     = 9,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter logic [31:0] FRAME_BYTES = 32'h0010_0000
) (
   input  logic               ACLK,
   input  logic               ARESET,
   ddr_wr_burst_ctrl_if.slave bus
);

   localparam int unsigned       DATA_W    = 256;
   localparam int unsigned       DEPTH     = 1 << FIFO_AW;
   localparam int unsigned       LVL_W     = FIFO_AW + 1;
   localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0]  LVL_BURST = LVL_W'(BURST_LEN);
   localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
   localparam logic [9:0]        LEN_FULL  = 10'(BURST_LEN);
   // One past the last byte of the frame; 33 bits so the sum cannot overflow.
   localparam logic [32:0]       ADDR_END  = {1'b0, BASE_ADDR} + {1'b0, FRAME_BYTES};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t               state_q, state_d;
   logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]     level_q, level_d;
   logic [31:0]          cur_addr_q, cur_addr_d;
   logic [31:0]          wr_adrs_q, wr_adrs_d;
   logic [9:0]           len_q, len_d;
   logic [9:0]           beat_q, beat_d;
   logic                 flush_q, flush_d;
   logic                 frame_pend_q, frame_pend_d;
   logic                 underflow_q, underflow_d;
   logic                 len_err_q, len_err_d;

   logic [DATA_W-1:0]    mem [DEPTH];

   logic                 push;
   logic                 pop;
   logic                 pop_empty;
   logic                 launch;
   logic [9:0]           beat_total;
   logic [32:0]          addr_sum;
   logic [31:0]          addr_adv;

   // ---------------------------------------------------------------------------
   // FIFO datapath: storage has no reset, only pointers and level do.
   // ---------------------------------------------------------------------------
   assign push      = bus.S_VALID && (level_q != LVL_FULL);
   assign pop       = bus.WR_FIFO_RE && (level_q != '0);
   assign pop_empty = bus.WR_FIFO_RE && (level_q == '0);

   always_ff @(posedge ACLK) begin
      if (push) begin
         mem[wr_ptr_q] <= bus.S_DATA;
      end
   end

   // First-word-fall-through: head word is a direct read at the read pointer.
   assign bus.WR_FIFO_DATA = mem[rd_ptr_q];
   assign bus.S_READY      = (level_q != LVL_FULL);

   // Beats already counted plus a pop landing in this same cycle, so a pop
   // coinciding with WR_DONE is still credited to the burst.
   assign beat_total = beat_q + 10'(pop);

   // Next burst address, wrapped to the frame base when it leaves the frame.
   assign addr_sum = {1'b0, cur_addr_q} + {18'd0, len_q, 5'd0};
   assign addr_adv = (addr_sum >= ADDR_END) ? BASE_ADDR : addr_sum[31:0];

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      level_d      = level_q;
      cur_addr_d   = cur_addr_q;
      wr_adrs_d    = wr_adrs_q;
      len_d        = len_q;
      beat_d       = beat_q;
      flush_d      = flush_q;
      frame_pend_d = frame_pend_q;
      underflow_d  = underflow_q | pop_empty;
      len_err_d    = len_err_q;
      launch       = 1'b0;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase

      case (state_q)
         IDLE: begin
            if (bus.FRAME_START) begin
               cur_addr_d = BASE_ADDR;
            end
            // Level is registered, so every word of the burst is already stored.
            if (bus.WR_READY && (level_q >= LVL_BURST)) begin
               len_d  = LEN_FULL;
               launch = 1'b1;
            end else if (bus.WR_READY && flush_q && (level_q != '0)) begin
               len_d   = 10'(level_q);
               flush_d = 1'b0;
               launch  = 1'b1;
            end else if (flush_q && (level_q == '0)) begin
               flush_d = 1'b0;
            end
            if (launch) begin
               state_d   = ISSUE;
               // A FRAME_START in the launch cycle must already steer this burst.
               wr_adrs_d = bus.FRAME_START ? BASE_ADDR : cur_addr_q;
               beat_d    = '0;
            end
         end

         ISSUE: begin
            state_d = BUSY;
            beat_d  = beat_total;
            if (bus.FRAME_START) begin
               frame_pend_d = 1'b1;
            end
         end

         BUSY: begin
            beat_d = beat_total;
            if (bus.FRAME_START) begin
               frame_pend_d = 1'b1;
            end
            if (bus.WR_DONE) begin
               state_d = IDLE;
               if (beat_total != len_q) begin
                  len_err_d = 1'b1;
               end
               cur_addr_d   = (frame_pend_q || bus.FRAME_START) ? BASE_ADDR : addr_adv;
               frame_pend_d = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // A new flush request wins over a clear in the same cycle, so a flush
      // that arrives while a short burst is launching is not lost.
      if (bus.S_FLUSH) begin
         flush_d = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         cur_addr_q   <= BASE_ADDR;
         wr_adrs_q    <= BASE_ADDR;
         len_q        <= '0;
         beat_q       <= '0;
         flush_q      <= 1'b0;
         frame_pend_q <= 1'b0;
         underflow_q  <= 1'b0;
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         cur_addr_q   <= cur_addr_d;
         wr_adrs_q    <= wr_adrs_d;
         len_q        <= len_d;
         beat_q       <= beat_d;
         flush_q      <= flush_d;
         frame_pend_q <= frame_pend_d;
         underflow_q  <= underflow_d;
         len_err_q    <= len_err_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.WR_START   = (state_q == ISSUE);
   assign bus.WR_ADRS    = wr_adrs_q;
   assign bus.WR_LEN     = len_q;
   assign bus.FIFO_LEVEL = level_q;
   assign bus.UNDERFLOW  = underflow_q;
   assign bus.LEN_ERR    = len_err_q;

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ddr_wr_burst_ctrl
// Directed bench for ddr_wr_burst_ctrl: a table of single-cycle FIFO vectors,
// then hand-written burst sequences. FRAME_BYTES is 0x1000 so that two full
// 64-beat bursts reach the end of the frame and wrap.
// -----------------------------------------------------------------------------
module tb_ddr_wr_burst_ctrl;

   logic ACLK;
   logic ARESET;

   ddr_wr_burst_ctrl_if #(.FIFO_AW(9)) bus ();

   ddr_wr_burst_ctrl #(
      .BURST_LEN   (64),
      .FIFO_AW     (9),
      .BASE_ADDR   (32'h0000_0000),
      .FRAME_BYTES (32'h0000_1000)
   ) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bus)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       valid;
      logic [7:0] tag;
      logic       re;
      int         lvl;
      logic       rdy;
      logic       uf;
      logic       hchk;
      logic [7:0] htag;
   } vec_t;

   vec_t          tbl [9];
   logic [255:0]  q [$];
   int            checks;
   int            errors;
   int            starts_seen;

   function automatic logic [255:0] mk(input int unsigned t);
      return {8{t}};
   endfunction

   task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
      if (bus.WR_START === 1'b1) starts_seen++;
   endtask

   task automatic do_reset();
      ARESET = 1'b1;
      step();
      ARESET = 1'b0;
      q.delete();
   endtask

   task automatic push_n(input int n, input int unsigned tag, input bit flush_last);
      for (int i = 0; i < n; i++) begin
         bus.S_VALID = 1'b1;
         bus.S_DATA  = mk(tag + i);
         bus.S_FLUSH = flush_last && (i == n - 1);
         step();
         q.push_back(mk(tag + i));
      end
      bus.S_VALID = 1'b0;
      bus.S_FLUSH = 1'b0;
   endtask

   task automatic wait_start();
      int n;
      n = 0;
      while (bus.WR_START !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      chk("wr_start_seen", bus.WR_START, 1'b1);
   endtask

   // Model write master: waits for the request, pops 'beats' words and
   // completes the burst. FRAME_START is pulsed during beat frame_at (if >= 0).
   task automatic do_burst(input logic [31:0] exp_adrs, input int exp_len,
                           input int beats, input int frame_at);
      bus.WR_READY = 1'b1;
      wait_start();
      bus.WR_READY = 1'b0;
      chk("wr_adrs", bus.WR_ADRS, exp_adrs);
      chk("wr_len", bus.WR_LEN, 256'(exp_len));
      step();
      chk("wr_start_one_cycle", bus.WR_START, 1'b0);
      bus.WR_FIFO_RE = 1'b1;
      for (int i = 0; i < beats; i++) begin
         chk("beat_data", bus.WR_FIFO_DATA, q[0]);
         bus.FRAME_START = (i == frame_at);
         step();
         void'(q.pop_front());
         bus.FRAME_START = 1'b0;
      end
      bus.WR_FIFO_RE = 1'b0;
      bus.WR_DONE = 1'b1;
      step();
      bus.WR_DONE = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      starts_seen = 0;
      ARESET = 1'b1;
      bus.S_VALID = 1'b0;
      bus.S_DATA = '0;
      bus.S_FLUSH = 1'b0;
      bus.FRAME_START = 1'b0;
      bus.WR_READY = 1'b0;
      bus.WR_FIFO_RE = 1'b0;
      bus.WR_DONE = 1'b0;

      //              valid tag    re  lvl rdy uf  hchk htag
      tbl[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b1, 1'b0, 1'b1, 8'h11};
      tbl[1] = '{1'b1, 8'h22, 1'b0, 2, 1'b1, 1'b0, 1'b1, 8'h11};
      tbl[2] = '{1'b1, 8'h33, 1'b1, 2, 1'b1, 1'b0, 1'b1, 8'h22};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b0, 1'b1, 8'h33};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b1, 1'b0, 8'h00};
      tbl[6] = '{1'b1, 8'h44, 1'b0, 1, 1'b1, 1'b1, 1'b1, 8'h44};
      tbl[7] = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 1'b1, 1'b1, 8'h44};
      tbl[8] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b1, 1'b0, 8'h00};

      // Reset state
      step();
      step();
      ARESET = 1'b0;
      chk("rst_level", bus.FIFO_LEVEL, 0);
      chk("rst_s_ready", bus.S_READY, 1'b1);
      chk("rst_wr_start", bus.WR_START, 1'b0);
      chk("rst_wr_adrs", bus.WR_ADRS, 32'h0);
      chk("rst_wr_len", bus.WR_LEN, 0);
      chk("rst_underflow", bus.UNDERFLOW, 1'b0);
      chk("rst_len_err", bus.LEN_ERR, 1'b0);

      // FIFO vector table (no bursts: WR_READY low)
      for (int i = 0; i < 9; i++) begin
         bus.S_VALID = tbl[i].valid;
         bus.S_DATA = mk(32'(tbl[i].tag));
         bus.WR_FIFO_RE = tbl[i].re;
         step();
         chk($sformatf("tbl%0d_level", i), bus.FIFO_LEVEL, 256'(tbl[i].lvl));
         chk($sformatf("tbl%0d_s_ready", i), bus.S_READY, tbl[i].rdy);
         chk($sformatf("tbl%0d_underflow", i), bus.UNDERFLOW, tbl[i].uf);
         if (tbl[i].hchk) chk($sformatf("tbl%0d_head", i), bus.WR_FIFO_DATA, mk(32'(tbl[i].htag)));
      end
      bus.S_VALID = 1'b0;
      bus.WR_FIFO_RE = 1'b0;
      do_reset();
      chk("reset_clears_underflow", bus.UNDERFLOW, 1'b0);

      // Two full bursts: 0x0, 0x800, then the frame wraps to 0x0
      push_n(64, 32'h1000, 1'b0);
      chk("level_64", bus.FIFO_LEVEL, 64);
      do_burst(32'h0, 64, 64, -1);
      chk("level_after_b1", bus.FIFO_LEVEL, 0);
      push_n(64, 32'h2000, 1'b0);
      do_burst(32'h800, 64, 64, -1);
      chk("len_err_clean", bus.LEN_ERR, 1'b0);

      // Flush of 10 words; S_FLUSH rides with the 10th word
      push_n(10, 32'h3000, 1'b1);
      do_burst(32'h0, 10, 10, -1);
      chk("level_after_flush", bus.FIFO_LEVEL, 0);

      // Flush must have cleared: 5 words with writer ready start nothing
      starts_seen = 0;
      bus.WR_READY = 1'b1;
      push_n(5, 32'h4000, 1'b0);
      for (int i = 0; i < 10; i++) step();
      chk("no_start_after_flush", starts_seen, 0);
      bus.WR_READY = 1'b0;
      push_n(59, 32'h4005, 1'b0);

      // Address advanced by 10*32; FRAME_START during BUSY rewinds the next one
      do_burst(32'h140, 64, 64, 10);
      push_n(64, 32'h6000, 1'b0);
      do_burst(32'h0, 64, 63, -1);
      chk("len_err_63_of_64", bus.LEN_ERR, 1'b1);
      chk("level_one_left", bus.FIFO_LEVEL, 1);

      // FRAME_START in IDLE: next burst at base instead of 0x800
      bus.FRAME_START = 1'b1;
      step();
      bus.FRAME_START = 1'b0;
      push_n(63, 32'h7000, 1'b0);
      do_burst(32'h0, 64, 64, -1);

      // Pop on empty FIFO
      bus.WR_FIFO_RE = 1'b1;
      step();
      bus.WR_FIFO_RE = 1'b0;
      chk("underflow_set", bus.UNDERFLOW, 1'b1);
      chk("underflow_level", bus.FIFO_LEVEL, 0);

      // Reset in BUSY with 100 words stored
      push_n(100, 32'h8000, 1'b0);
      bus.WR_READY = 1'b1;
      wait_start();
      bus.WR_READY = 1'b0;
      chk("b7_wr_adrs", bus.WR_ADRS, 32'h800);
      step();
      ARESET = 1'b1;
      step();
      chk("midrst_level", bus.FIFO_LEVEL, 0);
      chk("midrst_s_ready", bus.S_READY, 1'b1);
      chk("midrst_wr_start", bus.WR_START, 1'b0);
      chk("midrst_wr_adrs", bus.WR_ADRS, 32'h0);
      chk("midrst_wr_len", bus.WR_LEN, 0);
      chk("midrst_underflow", bus.UNDERFLOW, 1'b0);
      chk("midrst_len_err", bus.LEN_ERR, 1'b0);
      ARESET = 1'b0;
      q.delete();
      starts_seen = 0;
      bus.WR_READY = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk("midrst_idle_no_start", starts_seen, 0);
      bus.WR_READY = 1'b0;

      // Fill to 512: S_READY drops, extra push ignored, one pop restores it
      push_n(512, 32'h9000, 1'b0);
      chk("full_level", bus.FIFO_LEVEL, 512);
      chk("full_s_ready", bus.S_READY, 1'b0);
      bus.S_VALID = 1'b1;
      bus.S_DATA = mk(32'hDEAD);
      step();
      bus.S_VALID = 1'b0;
      chk("full_push_ignored", bus.FIFO_LEVEL, 512);
      chk("full_head", bus.WR_FIFO_DATA, q[0]);
      bus.WR_FIFO_RE = 1'b1;
      step();
      bus.WR_FIFO_RE = 1'b0;
      void'(q.pop_front());
      chk("after_pop_s_ready", bus.S_READY, 1'b1);
      chk("after_pop_level", bus.FIFO_LEVEL, 511);
      chk("after_pop_head", bus.WR_FIFO_DATA, q[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ddr_wr_burst_ctrl.md
DDR_WR_BURST_CTRL -- requirements
Module: ddr_wr_burst_ctrl

Interface
REQ-001 SHALL have parameter BURST_LEN, default 64, meaning beats per full burst (1..256).
REQ-002 SHALL have parameter FIFO_AW, default 9, meaning FIFO address width (depth 2^FIFO_AW = 512 words).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning frame buffer start byte address.
REQ-004 SHALL have parameter FRAME_BYTES, default 32'h0010_0000, meaning frame buffer size in bytes (multiple of 32).
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 ACLK  in  1  clock, all logic on rising edge.
REQ-007 ARESET  in  1  synchronous active-high reset.
REQ-008 S_VALID  in  1 / S_READY  out  1 / S_DATA  in  256  upstream word stream, transfer when VALID&READY.
REQ-009 S_FLUSH  in  1  pulse: drain remaining words as a short burst.
REQ-010 FRAME_START  in  1  pulse: restart address at BASE_ADDR.
REQ-011 WR_START  out  1 / WR_ADRS  out  32 / WR_LEN  out  10  burst request to AXI write master.
REQ-012 WR_READY  in  1  write master idle.
REQ-013 WR_FIFO_RE  in  1 / WR_FIFO_DATA  out  256  beat pop and current head word.
REQ-014 WR_DONE  in  1  one-cycle burst completion pulse.
REQ-015 FIFO_LEVEL  out  FIFO_AW+1  stored words; UNDERFLOW  out  1 sticky; LEN_ERR  out  1 sticky.

Function
REQ-016 FIFO SHALL be first-word-fall-through: WR_FIFO_DATA equals the oldest stored word whenever FIFO_LEVEL>0, with zero latency to WR_FIFO_RE.
REQ-017 WR_FIFO_RE with FIFO_LEVEL>0 SHALL pop one word that cycle; next cycle WR_FIFO_DATA shows the next word.
REQ-018 WR_FIFO_RE with FIFO_LEVEL==0 SHALL be ignored and set UNDERFLOW.
REQ-019 S_READY SHALL be (FIFO_LEVEL != 2^FIFO_AW), from registered level only.
REQ-020 Simultaneous push and pop SHALL leave FIFO_LEVEL unchanged; pointers wrap modulo depth.
REQ-021 States: IDLE, ISSUE, BUSY.
REQ-022 IDLE: when WR_READY=1 and FIFO_LEVEL>=BURST_LEN, latch len=BURST_LEN and go ISSUE.
REQ-023 IDLE: else when WR_READY=1, flush_pending=1 and 0<FIFO_LEVEL<BURST_LEN, latch len=FIFO_LEVEL and go ISSUE.
REQ-024 IDLE: flush_pending with FIFO_LEVEL==0 SHALL clear flush_pending.
REQ-025 ISSUE: WR_START=1 for exactly one cycle, WR_ADRS=cur_addr, WR_LEN=len; go BUSY.
REQ-026 BUSY: count popped beats; on WR_DONE go IDLE; set LEN_ERR if beat count != len.
REQ-027 On WR_DONE, cur_addr SHALL become cur_addr + len*32; if the result >= BASE_ADDR+FRAME_BYTES it SHALL be BASE_ADDR.
REQ-028 S_FLUSH SHALL set flush_pending. flush_pending SHALL clear when a short burst is issued or when REQ-024 applies. An S_FLUSH arriving with the final pushed word SHALL include that word.
REQ-029 FRAME_START in IDLE SHALL set cur_addr=BASE_ADDR next cycle.
REQ-030 FRAME_START in ISSUE or BUSY SHALL be held pending and applied at WR_DONE, overriding REQ-027.
REQ-031 WR_ADRS and WR_LEN SHALL hold their last values outside ISSUE.
REQ-032 A burst SHALL only be issued when all len words are already stored.

Reset
REQ-033 ARESET SHALL force the following, including mid-burst: state=IDLE, FIFO empty (FIFO_LEVEL=0), S_READY=1, WR_START=0, WR_ADRS=BASE_ADDR, WR_LEN=0, cur_addr=BASE_ADDR, flush_pending=0, FRAME_START pending=0, UNDERFLOW=0, LEN_ERR=0.
REQ-034 WR_FIFO_DATA SHALL be don't-care while FIFO_LEVEL=0.

Verification
REQ-035 Push 64 words D0..D63 with a model writer popping on RE -> one WR_START, WR_ADRS=0, WR_LEN=64; beats D0..D63 in order; next burst address 0x800.
REQ-036 Push 10 words then pulse S_FLUSH -> WR_LEN=10, all 10 popped, flush_pending cleared, next address +0x140.
REQ-037 Push 512 words with no pops -> S_READY=0 at level 512; one pop restores S_READY=1 next cycle.
REQ-038 FRAME_BYTES=0x1000 with two full bursts -> addresses 0x0, 0x800, then 0x0 (wrap).
REQ-039 FRAME_START during BUSY -> next WR_ADRS=BASE_ADDR; WR_FIFO_RE on empty FIFO -> UNDERFLOW=1; WR_DONE after 63 of 64 beats -> LEN_ERR=1.
REQ-040 ARESET asserted in BUSY with 100 words stored -> next cycle FIFO_LEVEL=0, state IDLE, all flags 0.
